// File: rtl/chip8_pkg.sv
// Shared constants and state encoding for the CHIP-8 display datapath.
package chip8_pkg;

  localparam int unsigned SCREEN_W = 64;
  localparam int unsigned SCREEN_H = 32;
  localparam int unsigned VRAM_AW  = 11;
  localparam int unsigned MEM_AW   = 12;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT,
    PIXEL,
    DONE
  } blit_state_t;

endpackage

// File: rtl/pixel_coord.sv
// Maps (sprite origin, row, column) to a vram address and an in-range flag.
// With CLIP set, pixels past the right/bottom edge are flagged out of range;
// otherwise they wrap around the screen.
module pixel_coord #(
  parameter bit          CLIP     = 1'b1,
  parameter int unsigned SCREEN_W = chip8_pkg::SCREEN_W,
  parameter int unsigned SCREEN_H = chip8_pkg::SCREEN_H
) (
  input  logic [6:0]                      x0,
  input  logic [6:0]                      y0,
  input  logic [3:0]                      row,
  input  logic [2:0]                      col,
  output logic [chip8_pkg::VRAM_AW-1:0]   vram_addr,
  output logic                            in_range
);
  import chip8_pkg::*;

  logic [6:0] px;
  logic [6:0] py;
  logic [6:0] px_eff;
  logic [6:0] py_eff;

  // Raw coordinates at 7 bits, then clip or wrap, then linearise.
  always_comb begin
    px = x0 + {4'd0, col};
    py = y0 + {3'd0, row};
    if (CLIP) begin
      in_range = (px < 7'(SCREEN_W)) && (py < 7'(SCREEN_H));
      px_eff   = px;
      py_eff   = py;
    end else begin
      in_range = 1'b1;
      px_eff   = px % 7'(SCREEN_W);
      py_eff   = py % 7'(SCREEN_H);
    end
    vram_addr = VRAM_AW'(py_eff) * VRAM_AW'(SCREEN_W) + VRAM_AW'(px_eff);
  end

endmodule

// File: rtl/sprite_blitter.sv
// DXYN draw path: fetches sprite rows from memory and XORs them into vram,
// flagging collision when a lit pixel is turned off. Fixed 10 cycles per row.
module sprite_blitter #(
  parameter bit          CLIP     = 1'b1,
  parameter int unsigned SCREEN_W = chip8_pkg::SCREEN_W,
  parameter int unsigned SCREEN_H = chip8_pkg::SCREEN_H
) (
  input  logic                            clk_in,
  input  logic                            rst_in,
  input  logic                            start,
  input  logic [7:0]                      x_in,
  input  logic [7:0]                      y_in,
  input  logic [3:0]                      n_in,
  input  logic [11:0]                     i_in,
  output logic                            busy,
  output logic                            done,
  output logic                            collision,
  output logic                            mem_rd_en,
  output logic [chip8_pkg::MEM_AW-1:0]    mem_addr,
  input  logic [7:0]                      mem_rd_data,
  output logic [chip8_pkg::VRAM_AW-1:0]   vram_addr,
  input  logic                            vram_rd_data,
  output logic                            vram_wr_en,
  output logic                            vram_wr_data
);
  import chip8_pkg::*;

  blit_state_t state;
  logic [6:0]  x0_q;
  logic [6:0]  y0_q;
  logic [3:0]  n_q;
  logic [3:0]  row_q;
  logic [2:0]  col_q;
  logic [11:0] i_q;
  logic [7:0]  shift_q;
  logic [3:0]  row_inc;
  logic        in_range;

  pixel_coord #(
    .CLIP     (CLIP),
    .SCREEN_W (SCREEN_W),
    .SCREEN_H (SCREEN_H)
  ) u_pixel_coord (
    .x0        (x0_q),
    .y0        (y0_q),
    .row       (row_q),
    .col       (col_q),
    .vram_addr (vram_addr),
    .in_range  (in_range)
  );

  // Next row index and the vram read-modify-write strobe for the current pixel.
  always_comb begin
    row_inc      = row_q + 4'd1;
    vram_wr_en   = (state == PIXEL) && shift_q[7] && in_range;
    vram_wr_data = ~vram_rd_data;
  end

  // Main FSM with registered handshake and memory-read outputs.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      collision <= 1'b0;
      mem_rd_en <= 1'b0;
      mem_addr  <= '0;
      x0_q      <= '0;
      y0_q      <= '0;
      n_q       <= '0;
      row_q     <= '0;
      col_q     <= '0;
      i_q       <= '0;
      shift_q   <= '0;
    end else begin
      done      <= 1'b0;
      mem_rd_en <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            // Start coordinates always wrap, independent of CLIP.
            x0_q      <= 7'(x_in % 8'(SCREEN_W));
            y0_q      <= 7'(y_in % 8'(SCREEN_H));
            n_q       <= n_in;
            i_q       <= i_in;
            collision <= 1'b0;
            row_q     <= '0;
            col_q     <= '0;
            if (n_in == 4'd0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state     <= FETCH;
              busy      <= 1'b1;
              mem_rd_en <= 1'b1;
              mem_addr  <= i_in;
            end
          end
        end
        FETCH: begin
          state <= WAIT;
        end
        WAIT: begin
          shift_q <= mem_rd_data;
          col_q   <= '0;
          state   <= PIXEL;
        end
        PIXEL: begin
          if (vram_wr_en && vram_rd_data) begin
            collision <= 1'b1;
          end
          shift_q <= {shift_q[6:0], 1'b0};
          col_q   <= col_q + 3'd1;
          if (col_q == 3'd7) begin
            row_q <= row_inc;
            if (row_inc == n_q) begin
              state <= DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              state     <= FETCH;
              mem_rd_en <= 1'b1;
              mem_addr  <= i_q + MEM_AW'(row_inc);
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/sprite_blitter.md
Name: sprite_blitter

Overview:
- Reads sprite bytes from main memory and draws them into the 64x32 vram with XOR, reporting pixel collision. This is the DXYN draw path.
- It is the read-side counterpart to the font/ROM loaders that write memory.
- Sits between the cpu and the memory/vram arrays. The cpu issues start/x/y/n/I, waits for done, then writes the collision flag into VF.

Parameters:
- CLIP, 1: 1 = pixels past the right or bottom edge are dropped; 0 = pixels wrap modulo 64/32.
- SCREEN_W, 64: vram width in pixels.
- SCREEN_H, 32: vram height in pixels.

Ports:
- clk_in  in  1  system clock; all state updates on posedge.
- rst_in  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- x_in  in  8  Vx, start column.
- y_in  in  8  Vy, start row.
- n_in  in  4  sprite height in rows.
- i_in  in  12  index register I, address of sprite row 0.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse when the draw is complete.
- collision  out  1  1 if any set pixel was cleared; valid with done, held until the next accepted start.
- mem_rd_en  out  1  memory read strobe.
- mem_addr  out  12  memory read address.
- mem_rd_data  in  8  read data, valid the cycle after mem_rd_en.
- vram_addr  out  11  py*64+px.
- vram_rd_data  in  1  combinational read of vram[vram_addr].
- vram_wr_en  out  1  vram write strobe, takes effect on posedge.
- vram_wr_data  out  1  write value.

Behaviour:
- Reset (async, rst_in=0): state=IDLE. busy, done, collision, mem_rd_en and vram_wr_en are 0. mem_addr and vram_addr are 0. No writes occur while in reset.
- Reset mid-draw aborts immediately. Rows already written stay in vram; no done pulse is produced.

State machine (IDLE, FETCH, WAIT, PIXEL, DONE):
- IDLE:
  - On start, latch x0=x_in mod 64, y0=y_in mod 32 (start coordinates always wrap), n, I.
  - Clear collision; row=0.
  - If n==0, go to DONE; otherwise go to FETCH.
  - start while not IDLE is ignored.
- FETCH: mem_rd_en=1, mem_addr=(I+row) mod 4096. Go to WAIT.
- WAIT: load mem_rd_data into an 8-bit shift register; col=0. Go to PIXEL.
- PIXEL (exactly 8 cycles per row, col 0..7, MSB first):
  - Coordinates: px=x0+col, py=y0+row, computed at 7 bits.
  - With CLIP=1: if px>=64 or py>=32, no write and no collision.
  - With CLIP=0: px mod 64, py mod 32.
  - If the pixel is in range and the sprite bit is 1: vram_wr_en=1, vram_wr_data=~vram_rd_data, and collision |= vram_rd_data.
  - If the sprite bit is 0: no write.
  - After col 7: row++. If row==n go to DONE, else go to FETCH.
- DONE: done=1 for one cycle, busy=0, go to IDLE.

Timing:
- Timing is fixed regardless of clipping or pixel data. With the start cycle = cycle 0, done is high in cycle 1+10n.
- For n=0, done is high in cycle 1.
- Back-to-back operation: start may be asserted in the cycle after done and is accepted.
- Exactly one vram write per cycle at most. The vram read-modify-write completes within one cycle.

Decomposition:
- chip8_pkg holds:
  - SCREEN_W and SCREEN_H.
  - VRAM_AW=11, MEM_AW=12.
  - The blit_state_t enum (IDLE, FETCH, WAIT, PIXEL, DONE).
- Sub-module pixel_coord (combinational): x0, y0, row, col, CLIP → vram_addr and in_range.
- The main FSM, counters and shift register live in sprite_blitter.

Test Plan:
- Font "0" (mem[0..4] = F0 90 90 90 F0), I=0, x=0, y=0, n=5, blank vram:
  - vram row 0 bits 0-3 = 1; rows 1-3 bits 0 and 3 = 1; row 4 bits 0-3 = 1.
  - collision=0; done at cycle 51; mem_addr sequence 0,1,2,3,4.
- Redraw the same sprite immediately → all 14 pixels cleared, collision=1.
- CLIP=1, byte FF, x=62, y=31, n=2:
  - Only vram[31*64+62] and vram[31*64+63] are written.
  - Row 1 produces no writes; done still at cycle 21.
  - Repeat with CLIP=0: pixels wrap to columns 0-5 and to row 0.
- x=70, y=40, n=1, byte 80 → pixel (6,8) set, because start coordinates wrap.
- n=0 → done at cycle 1, no mem_rd_en, no vram_wr_en, collision=0. A start asserted while busy is ignored.
- Reset (rst_in=0) during row 2 of a 5-row draw:
  - Outputs return to reset values in the same cycle; rows 0-1 remain in vram.
  - A new start after rst_in=1 completes normally.
